// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder: FSM state encoding and nibble width.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_look_ahead_adder_4bit.sv
// 4-bit carry look-ahead adder: all carries derived directly from generate/propagate terms.
module carry_look_ahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic       carry4
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  assign c_s[0] = Cin;
  assign c_s[1] = g_s[0] | (p_s[0] & Cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & Cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);

  assign sum    = p_s ^ c_s[3:0];
  assign carry4 = c_s[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit CLA, processing one nibble per clock, LSB first.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      Cin,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      carry_out
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] cla_a_s;
  logic [NIBBLE_W-1:0] cla_b_s;
  logic [NIBBLE_W-1:0] cla_sum_s;
  logic                cla_c4_s;

  assign cla_a_s = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign cla_b_s = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  carry_look_ahead_adder_4bit u_cla (
    .a      (cla_a_s),
    .b      (cla_b_s),
    .Cin    (carry_q),
    .sum    (cla_sum_s),
    .carry4 (cla_c4_s)
  );

  // Next-state, operand capture, nibble write-back and registered flag computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = Cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = cla_sum_s;
        carry_d = cla_c4_s;
        if (cnt_q == CNT_LAST) begin
          cout_d  = cla_c4_s;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any addition in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against a cycle-count/arithmetic model.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .Cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Model: remaining busy cycles, pending result, last delivered result
  int         rem = 0;
  logic [W:0] pend = '0;
  logic [W:0] res = '0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      rem = 0; e_busy = 1'b0; e_done = 1'b0; res = '0;
    end else begin
      e_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          rem    = N;
          pend   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          e_busy = 1'b1;
        end else begin
          e_busy = 1'b0;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          e_done = 1'b1;
          e_busy = 1'b0;
          res    = pend;
        end
      end
    end
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, e_busy});
    check("done", {{W{1'b0}}, done}, {{W{1'b0}}, e_done});
    if (!e_busy) check("result", {carry_out, sum}, res);
  endtask

  task automatic directed_add(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic [W:0] lit);
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < N; i++) step();
    check({name, "_done"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
    check({name, "_sum"}, {carry_out, sum}, lit);
    check({name, "_model"}, res, lit);
    step();
  endtask

  initial begin
    int pulses;
    int last_done;

    // Reset state
    step();
    step();
    check("reset_outputs", {busy, done, carry_out, sum[W-3:0]}, '0);
    rst_n = 1'b1;
    step();

    directed_add("t1", 16'h3A7F, 16'h12C5, 1'b0, 17'h04D44);
    directed_add("t2", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    directed_add("t3", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);

    // Start during RUN is ignored
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'hFFFF; b = 16'h1234; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("ignore_done", {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
    check("ignore_sum", {carry_out, sum}, 17'h00002);
    step();

    // Back-to-back with start held high
    start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    pulses = 0; last_done = -1;
    for (int i = 0; i < 22; i++) begin
      step();
      if (done) begin
        if (last_done >= 0) check("b2b_gap", (W+1)'(cyc - last_done), (W+1)'(5));
        last_done = cyc;
        pulses++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    check("b2b_pulses", (W+1)'(pulses), (W+1)'(4));
    start = 1'b0;
    for (int i = 0; i < N + 1; i++) step();

    // Asynchronous reset in the third RUN cycle
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, carry_out, sum[W-3:0]}, '0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * N + 2; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      step();
    end
    start = 1'b0;
    for (int i = 0; i < N + 2; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
